// File: rtl/ahb_ic_pkg.sv
// Shared types and constants for the AHB-Lite N-way interconnect.
//   htrans_t   : AHB transfer type encoding
//   hresp_t    : AHB-Lite response encoding (OKAY / ERROR)
//   ds_state_t : states of the built-in default subordinate
//   DEF_SEL    : all-ones pattern; its low BITS_FOR_SUBORDINATES bits mark
//                "default subordinate" in the data-phase select register
package ahb_ic_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01
  } hresp_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // The subordinate count is limited to 2**BITS_FOR_SUBORDINATES - 1, so the
  // all-ones index never names a real subordinate and can stand for DEF.
  localparam logic [15:0] DEF_SEL = 16'hFFFF;

endpackage

// File: rtl/ahb_ic_default_sub.sv
// Built-in default subordinate: answers any NONSEQ/SEQ transfer with the
// two-cycle AHB ERROR response and any IDLE/BUSY with a zero-wait OKAY.
// Also reused as the error generator for the wait-state timeout override.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (returns FSM to DS_IDLE)
//   start_i  : an erroring transfer is accepted this cycle
//   hready_o : ready toward the manager
//   hresp_o  : response toward the manager
module ahb_ic_default_sub
  import ahb_ic_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   start_i,
  output logic   hready_o,
  output hresp_t hresp_o
);

  ds_state_t state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hready_o = 1'b1;
    hresp_o  = OKAY;
    case (state_q)
      DS_IDLE: begin
        if (start_i) begin
          state_d = DS_ERR1;
        end
      end
      DS_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = ERROR;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = ERROR;
        // HREADY is high here, so a new erroring transfer can be accepted
        // directly and restart the sequence without passing through IDLE.
        state_d = start_i ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_ic_n.sv
// AHB-Lite single-manager interconnect for NO_OF_SUBORDINATES subordinates:
// combinational address decoder, registered data-phase response mux and a
// built-in default subordinate for unmapped addresses.
// Optional feature (define AHB_IC_TIMEOUT_EN): wait-state timeout that
// replaces a stalled subordinate's response with a two-cycle ERROR after
// TIMEOUT_CYCLES consecutive wait states.
// Ports:
//   HCLK, HRESET  : clock, synchronous active-high reset
//   HADDR, HTRANS : manager address phase
//   HSEL_S        : one-hot subordinate select (combinational from HADDR)
//   HRDATA_S      : packed subordinate read data, slot i = [i*DW +: DW]
//   HRESP_S       : packed subordinate responses, slot i = [i*2 +: 2]
//   HREADYOUT_S   : subordinate ready outputs
//   HRDATA/HRESP  : muxed data-phase response to the manager
//   HREADY        : muxed ready, also the HREADY input of every subordinate
module ahb_lite_ic_n
  import ahb_ic_pkg::*;
#(
  parameter int ADDR_WIDTH            = 32,
  parameter int DATA_WIDTH            = 32,
  parameter int NO_OF_SUBORDINATES    = 6,
  parameter int BITS_FOR_SUBORDINATES = 3,
  parameter int TIMEOUT_CYCLES        = 16
) (
  input  logic                                     HCLK,
  input  logic                                     HRESET,
  input  logic [ADDR_WIDTH-1:0]                    HADDR,
  input  logic [1:0]                               HTRANS,
  output logic [NO_OF_SUBORDINATES-1:0]            HSEL_S,
  input  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NO_OF_SUBORDINATES*2-1:0]          HRESP_S,
  input  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S,
  output logic [DATA_WIDTH-1:0]                    HRDATA,
  output logic [1:0]                               HRESP,
  output logic                                     HREADY
);

  localparam int BS   = BITS_FOR_SUBORDINATES;
  localparam int NSLT = 2 ** BS;
  localparam logic [BS-1:0] DEF = DEF_SEL[BS-1:0];

  logic [BS-1:0]         idx;
  logic                  sel_d;
  logic [BS-1:0]         dsel_q, dsel_d;
  logic                  hready_w;
  logic [1:0]            hresp_w;
  logic [DATA_WIDTH-1:0] rdata_w;
  logic                  def_start;
  logic                  def_hready;
  hresp_t                def_hresp;

  // Subordinate buses unpacked into arrays covering every possible index,
  // so dsel_q can index them directly; unused slots read as idle/ready.
  logic [DATA_WIDTH-1:0] rdata_a [NSLT];
  logic [1:0]            resp_a  [NSLT];
  logic                  rdy_a   [NSLT];

  // Address phase: decode
  assign idx = HADDR[ADDR_WIDTH-1 -: BS];

  always_comb begin
    HSEL_S = '0;
    sel_d  = 1'b1;
    for (int i = 0; i < NO_OF_SUBORDINATES; i++) begin
      if (int'(idx) == i) begin
        HSEL_S[i] = 1'b1;
        sel_d     = 1'b0;
      end
    end
  end

  assign dsel_d = sel_d ? DEF : idx;

  // Address -> data phase: target register advances only on HREADY
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q <= DEF;
    end else if (hready_w) begin
      dsel_q <= dsel_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NSLT; i++) begin
      rdata_a[i] = '0;
      resp_a[i]  = OKAY;
      rdy_a[i]   = 1'b1;
    end
    for (int i = 0; i < NO_OF_SUBORDINATES; i++) begin
      rdata_a[i] = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
      resp_a[i]  = HRESP_S[i*2 +: 2];
      rdy_a[i]   = HREADYOUT_S[i];
    end
  end

  assign def_start = sel_d & hready_w & HTRANS[1];

  ahb_ic_default_sub u_def_sub (
    .clk_i    (HCLK),
    .rst_i    (HRESET),
    .start_i  (def_start),
    .hready_o (def_hready),
    .hresp_o  (def_hresp)
  );

`ifdef AHB_IC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_start;
  logic          tmo_hready;
  hresp_t        tmo_hresp;

  // Counts consecutive wait states inserted by an external subordinate and
  // saturates; any completed data phase clears it.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (hready_w) begin
      tmo_cnt_d = '0;
    end else if ((dsel_q != DEF) && !rdy_a[dsel_q] && (tmo_cnt_q != TMO_MAX)) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Fire once, on the edge where the limit is reached, so the ERROR
  // sequence starts in the cycle the count shows TIMEOUT_CYCLES.
  assign tmo_start = (tmo_cnt_d == TMO_MAX) && (tmo_cnt_q != TMO_MAX);

  ahb_ic_default_sub u_tmo_sub (
    .clk_i    (HCLK),
    .rst_i    (HRESET),
    .start_i  (tmo_start),
    .hready_o (tmo_hready),
    .hresp_o  (tmo_hresp)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Data phase: response mux
  always_comb begin
    if (dsel_q == DEF) begin
      hready_w = def_hready;
      hresp_w  = def_hresp;
      rdata_w  = '0;
    end else begin
      hready_w = rdy_a[dsel_q];
      hresp_w  = resp_a[dsel_q];
      rdata_w  = rdata_a[dsel_q];
    end
`ifdef AHB_IC_TIMEOUT_EN
    // The override owns the bus for its two ERROR cycles; whatever the
    // stalled subordinate drives meanwhile is ignored.
    if (tmo_hresp == ERROR) begin
      hready_w = tmo_hready;
      hresp_w  = tmo_hresp;
      rdata_w  = '0;
    end
`endif
  end

  assign HREADY = hready_w;
  assign HRESP  = hresp_w;
  assign HRDATA = rdata_w;

  logic unused_bits;
  assign unused_bits = ^{HADDR[ADDR_WIDTH-BS-1:0], HTRANS[0]};

endmodule

// File: tb/tb_ahb_lite_ic_n.sv
// Self-checking bench for ahb_lite_ic_n (6 subordinates, 3 index bits).
// Completed data phases are checked against a queue of expected responses
// pushed when each NONSEQ address phase is accepted.
module tb_ahb_lite_ic_n;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 6;
  localparam int BS = 3;
  localparam int TO = 4;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic           HCLK = 1'b0;
  logic           HRESET;
  logic [AW-1:0]  HADDR;
  logic [1:0]     HTRANS;
  logic [NS-1:0]  HSEL_S;
  logic [NS*DW-1:0] HRDATA_S;
  logic [NS*2-1:0]  HRESP_S;
  logic [NS-1:0]  HREADYOUT_S;
  logic [DW-1:0]  HRDATA;
  logic [1:0]     HRESP;
  logic           HREADY;

  always #5 HCLK = ~HCLK;

  ahb_lite_ic_n #(
    .ADDR_WIDTH            (AW),
    .DATA_WIDTH            (DW),
    .NO_OF_SUBORDINATES    (NS),
    .BITS_FOR_SUBORDINATES (BS),
    .TIMEOUT_CYCLES        (TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL_S      (HSEL_S),
    .HRDATA_S    (HRDATA_S),
    .HRESP_S     (HRESP_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .HREADY      (HREADY)
  );

  logic [DW-1:0] sub_data [NS];
  logic [1:0]    sub_resp [NS];

  always_comb begin
    HRDATA_S = '0;
    HRESP_S  = '0;
    for (int k = 0; k < NS; k++) begin
      HRDATA_S[k*DW +: DW] = sub_data[k];
      HRESP_S[k*2 +: 2]    = sub_resp[k];
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    r;
  } exp_t;

  exp_t sb[$];
  bit   pend;
  int   total;
  int   bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [AW-1:0] a);
    exp_t e;
    int   id;
    id = int'(a[AW-1 -: BS]);
    if (id < NS) begin
      e.d = sub_data[id];
      e.r = sub_resp[id];
    end else begin
      e.d = '0;
      e.r = 2'b01;
    end
    return e;
  endfunction

  // Sample the current cycle, retire a finished data phase, record an
  // accepted address phase, then advance to just after the next edge.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (pend && HREADY) begin
      chk("sb_depth", 64'(sb.size()), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rdata", 64'(HRDATA), 64'(e.d));
        chk("resp", 64'(HRESP), 64'(e.r));
      end
      pend = 1'b0;
    end
    if (HREADY && HTRANS[1]) begin
      sb.push_back(predict(HADDR));
      pend = 1'b1;
      acc  = 1'b1;
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic step();
    bit a;
    tick(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    total  = 0;
    bad    = 0;
    pend   = 1'b0;
    HRESET = 1'b1;
    HADDR  = 32'hFFFF_FFFF;
    HTRANS = T_IDLE;
    HREADYOUT_S = '1;
    for (int k = 0; k < NS; k++) begin
      sub_data[k] = 32'hA000_0000 + 32'(k);
      sub_resp[k] = 2'b00;
    end
    sub_resp[3] = 2'b01;

    // reset defaults
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    #1;
    chk("rst_hready", 64'(HREADY), 64'(1));
    chk("rst_hresp", 64'(HRESP), 64'(0));
    chk("rst_hrdata", 64'(HRDATA), 64'(0));
    chk("rst_hsel", 64'(HSEL_S), 64'(0));

    // decode idx 2
    sub_data[2] = 32'hDEAD_BEEF;
    HADDR  = 32'h4000_0010;
    HTRANS = T_NONSEQ;
    #1;
    chk("hsel_idx2", 64'(HSEL_S), 64'(6'b000100));
    step();
    HTRANS = T_IDLE;
    HADDR  = 32'hFFFF_FFFF;
    #1;
    chk("dec_rdata", 64'(HRDATA), 64'(32'hDEAD_BEEF));
    chk("dec_resp", 64'(HRESP), 64'(0));
    step();

    // decode sweep over every index, back to back
    for (int i = 0; i < 8; i++) begin
      HADDR  = {3'(i), 29'h0000_0040};
      HTRANS = T_NONSEQ;
      #1;
      chk("sweep_hsel", 64'(HSEL_S), (i < NS) ? 64'(1 << i) : 64'(0));
      acc = 1'b0;
      for (int n = 0; n < 6 && !acc; n++) tick(acc);
      chk("sweep_acc", 64'(acc), 64'(1));
    end
    HTRANS = T_IDLE;
    HADDR  = 32'hFFFF_FFFF;
    repeat (3) step();

    // wait states on sub1; address moves to sub4 during the wait
    HADDR  = 32'h2000_0000;
    HTRANS = T_NONSEQ;
    step();
    HREADYOUT_S[1] = 1'b0;
    HADDR  = 32'h8000_0000;
    for (int w = 0; w < 3; w++) begin
      #1;
      chk("wait_hready", 64'(HREADY), 64'(0));
      chk("wait_hold_rdata", 64'(HRDATA), 64'(sub_data[1]));
      step();
    end
    HREADYOUT_S[1] = 1'b1;
    #1;
    chk("wait_release", 64'(HREADY), 64'(1));
    step();
    HADDR = 32'h6000_0000;
    step();
    HTRANS = T_IDLE;
    HADDR  = 32'hFFFF_FFFF;
    step();

    // default subordinate
    HADDR  = 32'hE000_0000;
    HTRANS = T_NONSEQ;
    #1;
    chk("hsel_def", 64'(HSEL_S), 64'(0));
    step();
    HTRANS = T_IDLE;
    #1;
    chk("err1_hready", 64'(HREADY), 64'(0));
    chk("err1_hresp", 64'(HRESP), 64'(1));
    step();
    #1;
    chk("err2_hready", 64'(HREADY), 64'(1));
    chk("err2_hresp", 64'(HRESP), 64'(1));
    step();
    #1;
    chk("idle_def_hready", 64'(HREADY), 64'(1));
    chk("idle_def_hresp", 64'(HRESP), 64'(0));
    step();

    // consecutive erroring transfers to the default subordinate
    HTRANS = T_NONSEQ;
    step();
    step();
    step();
    HTRANS = T_IDLE;
    #1;
    chk("b2b_err1", 64'(HREADY), 64'(0));
    step();
    step();
    step();

    // reset during DS_ERR1
    HTRANS = T_NONSEQ;
    step();
    HTRANS = T_IDLE;
    HRESET = 1'b1;
    #1;
    chk("mid_err1_hready", 64'(HREADY), 64'(0));
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    sb.delete();
    pend = 1'b0;
    #1;
    chk("mid_rst_hready", 64'(HREADY), 64'(1));
    chk("mid_rst_hresp", 64'(HRESP), 64'(0));
    step();

`ifdef AHB_IC_TIMEOUT_EN
    // stalled sub0 is cut off by the timeout
    HREADYOUT_S[0] = 1'b0;
    HADDR  = 32'h0000_0100;
    HTRANS = T_NONSEQ;
    #1;
    @(posedge HCLK);
    #1;
    HTRANS = T_IDLE;
    for (int w = 0; w < TO; w++) begin
      #1;
      chk("to_wait_hready", 64'(HREADY), 64'(0));
      chk("to_wait_hresp", 64'(HRESP), 64'(0));
      @(posedge HCLK);
      #1;
    end
    #1;
    chk("to_err1_hready", 64'(HREADY), 64'(0));
    chk("to_err1_hresp", 64'(HRESP), 64'(1));
    @(posedge HCLK);
    #1;
    #1;
    chk("to_err2_hready", 64'(HREADY), 64'(1));
    chk("to_err2_hresp", 64'(HRESP), 64'(1));
    @(posedge HCLK);
    #1;
    HREADYOUT_S[0] = 1'b1;
    #1;
    chk("to_free_hready", 64'(HREADY), 64'(1));
    chk("to_free_hresp", 64'(HRESP), 64'(0));
    HADDR = 32'hFFFF_FFFF;
    step();
`endif

    chk("sb_final", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
